fir_mac_ctrl: RTL and testbench

Sequencer for the FIR tap delay line and coefficient ROM. Per accepted input sample it:
- issues one shift strobe to the delay line;
- walks the tap address 0..N_TAPS-1, multiplying each tap by its coefficient and accumulating;
- presents one scaled output sample on a valid/ready interface.

It sits between the sample source and the output sink. It drives the delay line's shift/address inputs and the coefficient ROM address.

---
 rtl/fir_mac_ctrl.sv | 126 ++++++++++++
 tb/tb_fir_mac_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_ctrl.sv
// FIR tap sequencer: per accepted sample, one delay-line shift strobe, a MAC walk over all taps, then one scaled output.
// Define OUT_SAT_EN to saturate y to the signed WIDTH_DATA range instead of wrapping.
module fir_mac_ctrl #(
    parameter int WIDTH_DATA  = 8,
    parameter int WIDTH_COEF  = 8,
    parameter int N_TAPS      = 16,
    parameter int LOG2_N_TAPS = 4,
    parameter int OUT_SHIFT   = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH_DATA-1:0]  in_data,
    output logic                   shift_en,
    output logic [WIDTH_DATA-1:0]  shift_data,
    output logic [LOG2_N_TAPS-1:0] tap_addr,
    input  logic [WIDTH_DATA-1:0]  tap_data,
    input  logic [WIDTH_COEF-1:0]  coef_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH_DATA-1:0]  y,
    output logic                   busy
);
    localparam int WIDTH_PROD = WIDTH_DATA + WIDTH_COEF;
    localparam int WIDTH_ACC  = WIDTH_PROD + LOG2_N_TAPS;
    localparam logic [LOG2_N_TAPS-1:0] LAST_TAP = LOG2_N_TAPS'(N_TAPS - 1);

    typedef enum logic [2:0] {IDLE, SHIFT, MAC, DRAIN, OUT} state_t;

    state_t                 state_q, state_d;
    logic [WIDTH_DATA-1:0]  shift_data_q, shift_data_d;
    logic [LOG2_N_TAPS-1:0] tap_q, tap_d;
    logic [WIDTH_PROD-1:0]  prod_q, prod_d;
    logic [WIDTH_ACC-1:0]   acc_q, acc_d;
    logic [WIDTH_DATA-1:0]  y_q, y_d;
    logic [WIDTH_ACC-1:0]   acc_sum;
    logic [WIDTH_DATA-1:0]  y_next;

    assign acc_sum = acc_q + {{LOG2_N_TAPS{prod_q[WIDTH_PROD-1]}}, prod_q};

`ifdef OUT_SAT_EN
    localparam int WIDTH_S = WIDTH_ACC - OUT_SHIFT;
    logic [WIDTH_S-1:0] s;
    logic               sat_hi, sat_lo;

    // Out of range whenever the bits above the output sign differ from the sign of s.
    assign s      = acc_sum[WIDTH_ACC-1:OUT_SHIFT];
    assign sat_hi = !s[WIDTH_S-1] && (|s[WIDTH_S-2:WIDTH_DATA-1]);
    assign sat_lo =  s[WIDTH_S-1] && !(&s[WIDTH_S-2:WIDTH_DATA-1]);
    assign y_next = sat_hi ? {1'b0, {(WIDTH_DATA-1){1'b1}}} :
                    sat_lo ? {1'b1, {(WIDTH_DATA-1){1'b0}}} :
                             s[WIDTH_DATA-1:0];
`else
    assign y_next = acc_sum[OUT_SHIFT +: WIDTH_DATA];
`endif

    always_comb begin
        state_d      = state_q;
        shift_data_d = shift_data_q;
        tap_d        = tap_q;
        prod_d       = prod_q;
        acc_d        = acc_q;
        y_d          = y_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    shift_data_d = in_data;
                    acc_d        = '0;
                    tap_d        = '0;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                tap_d   = '0;
                state_d = MAC;
            end
            MAC: begin
                // Product is registered, so accumulation trails the tap address by one cycle.
                prod_d = $signed(tap_data) * $signed(coef_data);
                if (tap_q != '0) acc_d = acc_sum;
                if (tap_q == LAST_TAP) begin
                    state_d = DRAIN;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            DRAIN: begin
                acc_d   = acc_sum;
                y_d     = y_next;
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            shift_data_q <= '0;
            tap_q        <= '0;
            prod_q       <= '0;
            acc_q        <= '0;
            y_q          <= '0;
        end else begin
            state_q      <= state_d;
            shift_data_q <= shift_data_d;
            tap_q        <= tap_d;
            prod_q       <= prod_d;
            acc_q        <= acc_d;
            y_q          <= y_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign shift_en   = (state_q == SHIFT);
    assign out_valid  = (state_q == OUT);
    assign busy       = (state_q != IDLE);
    assign tap_addr   = tap_q;
    assign shift_data = shift_data_q;
    assign y          = y_q;

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Scoreboard bench for fir_mac_ctrl with a behavioural delay line and coefficient table.
`timescale 1ns/1ps
module tb_fir_mac_ctrl;
    localparam int WD = 8;
    localparam int WC = 8;
    localparam int NT = 16;
    localparam int LG = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WD-1:0] in_data = '0;
    logic          shift_en;
    logic [WD-1:0] shift_data;
    logic [LG-1:0] tap_addr;
    logic [WD-1:0] tap_data;
    logic [WC-1:0] coef_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [WD-1:0] y;
    logic          busy;

    logic [WD-1:0] dl [NT] = '{default: '0};
    logic [WC-1:0] coef [NT] = '{default: '0};

    int checks = 0;
    int failures = 0;
    logic [WD-1:0] exp_q [$];
    int since = 1000;
    int cyc = 0;
    int last_acc = 0;
    bit b2b_mode = 1'b0;
    bit b2b_prev = 1'b0;

    always #5 clk = ~clk;

    fir_mac_ctrl #(
        .WIDTH_DATA(WD), .WIDTH_COEF(WC), .N_TAPS(NT), .LOG2_N_TAPS(LG), .OUT_SHIFT(7)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .shift_en(shift_en), .shift_data(shift_data), .tap_addr(tap_addr), .tap_data(tap_data),
        .coef_data(coef_data), .out_valid(out_valid), .out_ready(out_ready), .y(y), .busy(busy)
    );

    assign tap_data  = dl[tap_addr];
    assign coef_data = coef[tap_addr];

    always @(posedge clk) begin
        if (shift_en) begin
            for (int i = NT - 1; i > 0; i--) dl[i] <= dl[i-1];
            dl[0] <= shift_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard pop on output handshake, plus per-sample timing relative to the accept cycle.
    always @(negedge clk) begin
        logic [WD-1:0] e;
        cyc++;
        if (!reset) begin
            since = 1000;
            b2b_prev = 1'b0;
        end else begin
            if (since < 1000) since++;
            chk("shift_en", 32'(shift_en), 32'(since == 1));
            if (since >= 2 && since <= 17) chk("tap_addr", 32'(tap_addr), 32'(since - 2));
            if (since <= 19) chk("out_valid_latency", 32'(out_valid), 32'(since == 19));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got y=%0d required no output", y);
                end else begin
                    e = exp_q.pop_front();
                    chk("y", 32'(y), 32'(e));
                end
            end
            if (in_valid && in_ready) begin
                if (b2b_mode && b2b_prev) chk("accept_gap", 32'(cyc - last_acc), 32'd20);
                b2b_prev = b2b_mode;
                last_acc = cyc;
                since = 0;
            end
        end
    end

    task automatic send(input logic [WD-1:0] d, input logic [WD-1:0] e, input bit hold);
        int n;
        n = 0;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got in_ready=0 required 1");
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            if (!hold) in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || !in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || !in_ready) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: got pending=%0d required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_shift_en"}, 32'(shift_en), 32'd0);
        chk({tag, "_shift_data"}, 32'(shift_data), 32'd0);
        chk({tag, "_tap_addr"}, 32'(tap_addr), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_y"}, 32'(y), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int s;
        int n;
        logic [WD-1:0] e;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_cleared("reset");
        reset = 1'b1;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Impulse with all coefficients 64: 100*64>>>7 = 50 while the impulse is in the line
        for (int i = 0; i < NT; i++) coef[i] = 8'd64;
        send(8'd100, 8'd50, 1'b0);
        for (int i = 1; i <= NT; i++) send(8'd0, (i < NT) ? 8'd50 : 8'd0, 1'b0);
        wait_idle();

        // Overflow: coefficients 127, k samples of 127 give s = floor(k*16129/128) = 126*k
        for (int i = 0; i < NT; i++) coef[i] = 8'd127;
        for (int k = 1; k <= NT; k++) begin
            s = 126 * k;
`ifdef OUT_SAT_EN
            e = (s > 127) ? 8'd127 : 8'(s);
`else
            e = 8'(s);
`endif
            send(8'd127, e, 1'b0);
        end
        wait_idle();

        // Negative corner under backpressure: (-128)*(-128)>>>7 = 128
        for (int i = 0; i < NT; i++) coef[i] = 8'd0;
        coef[0] = 8'h80;
`ifdef OUT_SAT_EN
        e = 8'h7f;
`else
        e = 8'h80;
`endif
        out_ready = 1'b0;
        send(8'h80, e, 1'b0);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid_seen", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_y", 32'(y), 32'(e));
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back with only h0=64: y = floor(x/2), includes -3 -> -2
        coef[0] = 8'd64;
        b2b_mode = 1'b1;
        send(8'd10, 8'd5, 1'b1);
        send(8'(-10), 8'(-5), 1'b1);
        send(8'd20, 8'd10, 1'b1);
        send(8'(-3), 8'(-2), 1'b1);
        in_valid = 1'b0;
        wait_idle();
        b2b_mode = 1'b0;

        // Reset during MAC at tap 7 aborts the sample
        send(8'd100, 8'd50, 1'b0);
        n = 0;
        @(negedge clk);
        while (!(busy && tap_addr == 4'd7) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("abort_tap7_reached", 32'(tap_addr), 32'd7);
        #2;
        reset = 1'b0;
        #1;
        chk_cleared("abort");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        repeat (25) @(negedge clk);
        @(posedge clk);
        #1;
        send(8'd40, 8'd20, 1'b0);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
